// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_pkg : scan-slot states and display constants           Rev 1.0
// ----------------------------------------------------------------------------
package seg_scan_pkg;

  typedef enum logic [1:0] {
    DIG_TENS  = 2'd0,
    GAP_T     = 2'd1,
    DIG_UNITS = 2'd2,
    GAP_U     = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] TENS_ON  = 2'b01;
  localparam logic [1:0] UNITS_ON = 2'b10;
  localparam logic [1:0] ALL_OFF  = 2'b11;

  function automatic scan_state_e next_slot(input scan_state_e s);
    case (s)
      DIG_TENS:  return GAP_T;
      GAP_T:     return DIG_UNITS;
      DIG_UNITS: return GAP_U;
      default:   return DIG_TENS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg7_digit_enc : BCD digit to seven-segment code (a..g)          Rev 1.0
// ----------------------------------------------------------------------------
module seg7_digit_enc
  import seg_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_driver : two-digit multiplexed 7-seg scanner with blink  Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_THRESH = 3,
  parameter int BLINK_FRAMES = 64,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] count_value,
  output logic [6:0]           seg,
  output logic [1:0]           dig_n,
  output logic                 frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0]     FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_WIDTH-1:0] THRESH   = CNT_WIDTH'(BLINK_THRESH);

  scan_state_e          state_q, state_d;
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic                 run_q, run_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0]     frm_q, frm_d;
  logic                 blink_ph_q, blink_ph_d;
  logic [6:0]           seg_q, seg_d;
  logic [1:0]           dig_n_q, dig_n_d;
  logic                 frame_tick_q, frame_tick_d;

  logic                 tick;
  logic [1:0]           tens;
  logic [CNT_WIDTH-1:0] tens_base;
  logic [3:0]           units;
  logic [3:0]           digit;
  logic [6:0]           digit_seg;
  logic                 blank_digit;

  // Latched count is at most 31, so the tens digit is found by comparison.
  always_comb begin
    if (cnt_q >= CNT_WIDTH'(30)) begin
      tens = 2'd3; tens_base = CNT_WIDTH'(30);
    end else if (cnt_q >= CNT_WIDTH'(20)) begin
      tens = 2'd2; tens_base = CNT_WIDTH'(20);
    end else if (cnt_q >= CNT_WIDTH'(10)) begin
      tens = 2'd1; tens_base = CNT_WIDTH'(10);
    end else begin
      tens = 2'd0; tens_base = '0;
    end
    units = 4'(cnt_q - tens_base);
  end

  assign digit       = (state_q == DIG_TENS) ? {2'b00, tens} : units;
  assign blank_digit = (cnt_q <= THRESH) && !blink_ph_q;

  seg7_digit_enc u_enc (
    .digit (digit),
    .seg   (digit_seg)
  );

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    run_d      = run_q;
    cnt_d      = cnt_q;
    frm_d      = frm_q;
    blink_ph_d = blink_ph_q;
    tick       = run_q && (pre_q == PRE_LAST);

    if (!en) begin
      state_d    = GAP_U;
      pre_d      = '0;
      run_d      = 1'b0;
      frm_d      = '0;
      blink_ph_d = 1'b1;
    end else if (!run_q) begin
      // First enabled cycle holds pre at 0 so the idle gap is a full slot.
      run_d = 1'b1;
    end else if (tick) begin
      pre_d   = '0;
      state_d = next_slot(state_q);
      if (state_q == GAP_U) begin
        cnt_d = count_value;
      end
      // Frames are counted as their digits finish, so frame 0 starts at phase 1.
      if (state_q == DIG_UNITS) begin
        if (frm_q == FRM_LAST) begin
          frm_d      = '0;
          blink_ph_d = ~blink_ph_q;
        end else begin
          frm_d = frm_q + 1'b1;
        end
      end
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_comb begin
    seg_d        = SEG_BLANK;
    dig_n_d      = ALL_OFF;
    frame_tick_d = (state_q == DIG_TENS) && (pre_q == '0);
    case (state_q)
      DIG_TENS: begin
        dig_n_d = TENS_ON;
        if (!blank_digit && (tens != 2'd0)) seg_d = digit_seg;
      end
      DIG_UNITS: begin
        dig_n_d = UNITS_ON;
        if (!blank_digit) seg_d = digit_seg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= GAP_U;
      pre_q        <= '0;
      run_q        <= 1'b0;
      cnt_q        <= '0;
      frm_q        <= '0;
      blink_ph_q   <= 1'b1;
      seg_q        <= SEG_BLANK;
      dig_n_q      <= ALL_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
      frm_q        <= frm_d;
      blink_ph_q   <= blink_ph_d;
      seg_q        <= seg_d;
      dig_n_q      <= dig_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_n      = dig_n_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg_scan_driver : self-checking bench for seg_scan_driver      Rev 1.0
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int TH = 3;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CW-1:0] count_value;
  logic [6:0]    seg;
  logic [1:0]    dig_n;
  logic          frame_tick;

  int errors = 0;
  int checks = 0;

  seg_scan_driver #(
    .SCAN_DIV     (SD),
    .BLINK_THRESH (TH),
    .BLINK_FRAMES (BF),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .count_value (count_value),
    .seg         (seg),
    .dig_n       (dig_n),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Display from elapsed enabled cycles: n = enabled edges since idle.
  // Slot (n-1)/SD - 1 counts from the first tens slot; 4 slots per frame.
  task automatic model_out(input int n, input int v,
                           output logic [6:0] s, output logic [1:0] d, output logic ft);
    int  slot;
    int  st;
    int  frame;
    bit  hide;
    s  = 7'b0;
    d  = 2'b11;
    ft = 1'b0;
    if (n > SD) begin
      slot  = (n - 1) / SD - 1;
      st    = slot % 4;
      frame = slot / 4;
      hide  = (v <= TH) && (((frame / BF) % 2) == 1);
      if (st == 0) begin
        d  = 2'b01;
        ft = ((n - 1) % SD) == 0;
        if (!hide && (v / 10) != 0) s = code(v / 10);
      end else if (st == 2) begin
        d = 2'b10;
        if (!hide) s = code(v % 10);
      end
    end
  endtask

  int         m_n = 0;
  int         m_val = 0;
  logic [6:0] exp_seg;
  logic [1:0] exp_dig;
  logic       exp_ft;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        exp_seg = 7'b0; exp_dig = 2'b11; exp_ft = 1'b0;
        m_n = 0; m_val = 0;
      end else begin
        model_out(m_n, m_val, exp_seg, exp_dig, exp_ft);
        if (en) begin
          m_n++;
          if (m_n - 1 >= SD && ((m_n - 1 - SD) % (4 * SD)) == 0) m_val = int'(count_value);
        end else begin
          m_n = 0;
        end
      end
      #1;
      chk("model_seg", 8'(seg), 8'(exp_seg));
      chk("model_dig_n", 8'(dig_n), 8'(exp_dig));
      chk("model_frame_tick", 8'(frame_tick), 8'(exp_ft));
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ft(input int limit, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_tick !== 1'b1 && cyc < limit);
    if (frame_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: no pulse within %0d cycles", limit);
    end
  endtask

  task automatic restart(input int cv);
    int c;
    en = 1'b0;
    count_value = CW'(cv);
    @(negedge clk);
    en = 1'b1;
    wait_ft(6 * SD, c);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    en = 1'b1;
    count_value = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_seg", 8'(seg), 8'h00);
      chk("rst_dig_n", 8'(dig_n), 8'h03);
      chk("rst_frame_tick", 8'(frame_tick), 8'h00);
    end

    rst_n = 1'b1;
    count_value = CW'(14);
    wait_ft(6 * SD, cyc);
    chk("first_tick_edge", 8'(cyc - 1), 8'(SD + 1));
    chk("t14_dig_n", 8'(dig_n), 8'b01);
    chk("t14_seg", 8'(seg), 8'b0110000);
    skip(1);
    chk("tick_one_cycle", 8'(frame_tick), 8'h00);
    skip(SD - 1);
    chk("gapt_dig_n", 8'(dig_n), 8'b11);
    chk("gapt_seg", 8'(seg), 8'h00);
    skip(SD);
    chk("u14_dig_n", 8'(dig_n), 8'b10);
    chk("u14_seg", 8'(seg), 8'b0110011);
    skip(SD);
    chk("gapu_dig_n", 8'(dig_n), 8'b11);
    skip(SD);
    chk("frame2_tick", 8'(frame_tick), 8'h01);
    chk("frame2_seg", 8'(seg), 8'b0110000);

    restart(7);
    chk("lz7_tens_seg", 8'(seg), 8'h00);
    chk("lz7_tens_dig_n", 8'(dig_n), 8'b01);
    skip(2 * SD);
    chk("lz7_units_seg", 8'(seg), 8'b1110000);

    restart(0);
    chk("lz0_tens_seg", 8'(seg), 8'h00);
    skip(2 * SD);
    chk("lz0_units_seg", 8'(seg), 8'b1111110);

    restart(17);
    skip(2 * SD);
    chk("latch_old_seg", 8'(seg), 8'b1110000);
    count_value = CW'(16);
    skip(1);
    chk("latch_hold_seg", 8'(seg), 8'b1110000);
    wait_ft(6 * SD, cyc);
    skip(2 * SD);
    chk("latch_new_seg", 8'(seg), 8'b1011111);

    restart(2);
    for (int f = 0; f < 5; f++) begin
      if (f > 0) wait_ft(6 * SD, cyc);
      skip(2 * SD);
      chk("blink2_units_seg", 8'(seg), (((f / 2) % 2) == 0) ? 8'b1101101 : 8'h00);
    end

    restart(4);
    for (int f = 0; f < 4; f++) begin
      if (f > 0) wait_ft(6 * SD, cyc);
      skip(2 * SD);
      chk("noblink4_units_seg", 8'(seg), 8'b0110011);
    end

    restart(9);
    en = 1'b0;
    skip(1);
    chk("dis_lag_dig_n", 8'(dig_n), 8'b01);
    skip(1);
    chk("dis_dig_n", 8'(dig_n), 8'b11);
    chk("dis_seg", 8'(seg), 8'h00);
    en = 1'b1;
    wait_ft(6 * SD, cyc);
    chk("reen_tick_edge", 8'(cyc - 1), 8'(SD + 1));

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) count_value = CW'($urandom_range(0, 5));
        else count_value = CW'($urandom_range(0, 31));
      end
      en    = ($urandom_range(0, 149) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
